// File: rtl/lcd_pixel_framer.sv
// Normalises the PPU pixel stream to exactly WIDTH pixels per line for the LCD write side.
// Optional LCD_FRAMER_STATS_EN adds frame/error statistics counters.
module lcd_pixel_framer #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 144,
  parameter int unsigned DW     = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_mode,
  input  logic          lcd_on,
  input  logic          is_gbc,
  output logic          out_clkena,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_mode,
  output logic          out_on,
  output logic          frame_done,
  output logic          err_short,
  output logic          err_long
`ifdef LCD_FRAMER_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    short_cnt,
  output logic [7:0]    long_cnt
`endif
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMax  = YW'(HEIGHT);

  typedef enum logic [1:0] {StOff, StSkip, StActive, StPad} state_e;

  state_e        state_q, state_d;
  logic          pad_skip_q, pad_skip_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          full_q, full_d;
  logic [1:0]    mode_q;

  logic          clkena_q, clkena_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    omode_q;
  logic          on_q;
  logic          fdone_q, fdone_d;
  logic          short_q, long_q;

  logic          mode_edge, vb_entry, hb_entry, start_pad, running, x_last;
  logic          accept, pad_emit, short_ev, long_ev;
  logic [DW-1:0] blank;

  assign mode_edge = in_mode != mode_q;
  assign vb_entry  = mode_edge && (in_mode == 2'b01);
  assign hb_entry  = mode_edge && (in_mode == 2'b00);
  assign start_pad = hb_entry && !full_q && (x_q != '0);
  assign running   = (state_q == StSkip) || (state_q == StActive);
  assign x_last    = x_q == XLast;
  assign blank     = is_gbc ? '1 : '0;

  // A pixel is taken only on a quiet cycle of an open, in-frame line.
  assign accept   = running && lcd_on && in_valid && !vb_entry && !start_pad &&
                    (in_mode != 2'b01) && !full_q && (y_q < YMax);
  assign pad_emit = (state_q == StPad) && lcd_on && !vb_entry;
  assign long_ev  = lcd_on && in_valid && (state_q != StOff) && !accept;
  assign short_ev = lcd_on && (state_q != StOff) &&
                    ((vb_entry && (y_q < YMax)) || (running && !vb_entry && start_pad));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StOff;
      pad_skip_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      full_q     <= 1'b0;
      mode_q     <= 2'b00;
      clkena_q   <= 1'b0;
      data_q     <= '0;
      omode_q    <= 2'b00;
      on_q       <= 1'b0;
      fdone_q    <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      pad_skip_q <= pad_skip_d;
      x_q        <= x_d;
      y_q        <= y_d;
      full_q     <= full_d;
      mode_q     <= in_mode;
      clkena_q   <= clkena_d;
      data_q     <= data_d;
      omode_q    <= in_mode;
      on_q       <= lcd_on;
      fdone_q    <= fdone_d;
      short_q    <= short_q | short_ev;
      long_q     <= long_q | long_ev;
    end
  end

  always_comb begin
    state_d    = state_q;
    pad_skip_d = pad_skip_q;
    x_d        = x_q;
    y_d        = y_q;
    full_d     = full_q;
    case (state_q)
      StOff: begin
        if (lcd_on) state_d = StSkip;
      end
      StSkip, StActive: begin
        if (vb_entry) begin
          x_d     = '0;
          y_d     = '0;
          full_d  = 1'b0;
          state_d = StActive;
        end else if (start_pad) begin
          state_d    = StPad;
          pad_skip_d = state_q == StSkip;
        end else begin
          if (hb_entry) full_d = 1'b0;
          if (accept) begin
            if (x_last) begin
              x_d    = '0;
              y_d    = y_q + 1'b1;
              full_d = 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      StPad: begin
        if (vb_entry) begin
          x_d     = '0;
          y_d     = '0;
          full_d  = 1'b0;
          state_d = StActive;
        end else if (x_last) begin
          x_d     = '0;
          y_d     = y_q + 1'b1;
          full_d  = 1'b0;
          state_d = pad_skip_q ? StSkip : StActive;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = StOff;
    endcase
    // Switching the LCD off overrides everything; sticky errors are left alone.
    if (!lcd_on) begin
      state_d = StOff;
      x_d     = '0;
      y_d     = '0;
      full_d  = 1'b0;
    end
  end

  always_comb begin
    clkena_d = accept || pad_emit;
    data_d   = data_q;
    if (accept) data_d = (state_q == StSkip) ? blank : in_data;
    else if (pad_emit) data_d = blank;
    fdone_d = lcd_on && (state_q != StOff) && vb_entry;
  end

  assign out_clkena = clkena_q;
  assign out_data   = data_q;
  assign out_mode   = omode_q;
  assign out_on     = on_q;
  assign frame_done = fdone_q;
  assign err_short  = short_q;
  assign err_long   = long_q;

`ifdef LCD_FRAMER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  short_cnt_q, long_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      short_cnt_q <= '0;
      long_cnt_q  <= '0;
    end else if (ce) begin
      if (fdone_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (short_ev && (short_cnt_q != 8'hFF)) short_cnt_q <= short_cnt_q + 8'd1;
      if (long_ev && (long_cnt_q != 8'hFF)) long_cnt_q <= long_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign short_cnt = short_cnt_q;
  assign long_cnt  = long_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_pixel_framer.sv
// Self-checking bench for lcd_pixel_framer: directed line/frame sequences with random
// pixel data and line lengths, scored against a line-level reference model.
module tb_lcd_pixel_framer;

  localparam int W = 160;
  localparam int H = 144;

  logic        clk = 1'b0;
  logic        reset_n, ce, in_valid, lcd_on, is_gbc;
  logic [14:0] in_data;
  logic [1:0]  in_mode;
  logic        out_clkena, out_on, frame_done, err_short, err_long;
  logic [14:0] out_data;
  logic [1:0]  out_mode;
`ifdef LCD_FRAMER_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  short_cnt, long_cnt;
`endif

  lcd_pixel_framer #(.WIDTH(W), .HEIGHT(H), .DW(15)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .lcd_on(lcd_on), .is_gbc(is_gbc), .out_clkena(out_clkena),
    .out_data(out_data), .out_mode(out_mode), .out_on(out_on), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long)
`ifdef LCD_FRAMER_STATS_EN
    , .frame_cnt(frame_cnt), .short_cnt(short_cnt), .long_cnt(long_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model state.
  logic [14:0] exp_q[$];
  logic [14:0] got_q[$];
  int          y_m;
  bit          skip_m, short_m, long_m;
  int          fd_exp, fd_cnt, fd_since_rst;
  logic [14:0] last_px;
  bit          mon_en;

  always @(negedge clk) begin
    if (mon_en && out_clkena) got_q.push_back(out_data);
    if (mon_en && frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] blank_px();
    return is_gbc ? 15'h7FFF : 15'h0000;
  endfunction

  task automatic tick(input logic v, input logic [14:0] d, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic cmp_px(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_pix"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_err_short"}, err_short, short_m);
    chk({tag, "_err_long"}, err_long, long_m);
    chk({tag, "_frames"}, fd_cnt, fd_exp);
  endtask

  // Accept one pixel in the model: it is kept only inside an open, in-frame line.
  task automatic model_px(input int idx, input logic [14:0] d, input bit drop);
    if (drop || idx >= W) begin
      long_m = 1'b1;
    end else begin
      last_px = skip_m ? blank_px() : d;
      exp_q.push_back(last_px);
    end
  endtask

  task automatic model_line_end(input int n, input bit drop);
    if (!drop && n > 0 && n < W) begin
      for (int i = n; i < W; i++) exp_q.push_back(blank_px());
      last_px = blank_px();
      short_m = 1'b1;
    end
    if (!drop && n > 0) y_m++;
  endtask

  task automatic do_line(input int n, input bit seq);
    logic [14:0] d;
    bit drop;
    int hb;
    drop = y_m >= H;
    tick(1'b0, 15'h0, 2'b10);
    tick(1'b0, 15'h0, 2'b10);
    for (int i = 0; i < n; i++) begin
      d = seq ? 15'(i) : 15'($urandom);
      tick(1'b1, d, 2'b11);
      model_px(i, d, drop);
    end
    hb = (!drop && n > 0 && n < W) ? W - n + 2 : 3;
    for (int i = 0; i < hb; i++) tick(1'b0, 15'h0, 2'b00);
    model_line_end(n, drop);
  endtask

  task automatic do_vblank();
    for (int i = 0; i < 4; i++) tick(1'b0, 15'h0, 2'b01);
    fd_exp++;
    fd_since_rst++;
    if (y_m < H) short_m = 1'b1;
    y_m = 0;
    skip_m = 1'b0;
  endtask

  initial begin
    logic [14:0] d;
    reset_n = 1'b0; ce = 1'b1; lcd_on = 1'b0; is_gbc = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = 2'b00;
    mon_en = 1'b1; y_m = 0; skip_m = 1'b1; short_m = 0; long_m = 0;
    fd_exp = 0; fd_cnt = 0; fd_since_rst = 0; last_px = '0;
    #13;
    chk("rst_clkena", out_clkena, 0); chk("rst_data", out_data, 0);
    chk("rst_mode", out_mode, 0);     chk("rst_on", out_on, 0);
    chk("rst_frame_done", frame_done, 0);
    chk_flags("rst");
    @(negedge clk); reset_n = 1'b1; #1;

    // 1: one blank frame, then a frame of sequential data.
    lcd_on = 1'b1;
    tick(1'b0, 15'h0, 2'b00);
    chk("on_out_on", out_on, 1);
    for (int l = 0; l < H; l++) begin
      do_line(W, 1'b1);
      if (l == 0 || l == H - 1) cmp_px("f1_line");
    end
    cmp_px("f1_rest");
    do_vblank();
    chk("vb_out_mode", out_mode, 2'b01);
    chk_flags("f1");
    for (int l = 0; l < H; l++) do_line(W, 1'b1);
    cmp_px("f2");
    do_vblank();
    chk_flags("f2");

    // 2: short line gets padded.
    is_gbc = 1'($urandom_range(0, 1));
    do_line(150, 1'b0);
    cmp_px("short_line");
    chk_flags("short_line");

    // 3: long line is truncated without padding.
    do_line(165, 1'b0);
    cmp_px("long_line");
    chk_flags("long_line");

    // 4: random line lengths up to y=100, then vblank while padding.
    while (y_m < 100) begin
      do_line($urandom_range(1, W + 10), 1'b0);
      cmp_px("rand_line");
    end
    tick(1'b0, 15'h0, 2'b10);
    for (int i = 0; i < 150; i++) begin
      d = 15'($urandom);
      tick(1'b1, d, 2'b11);
      model_px(i, d, 1'b0);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 15'h0, 2'b00);
    for (int i = 0; i < 3; i++) exp_q.push_back(blank_px());
    short_m = 1'b1;
    tick(1'b0, 15'h0, 2'b01);
    chk("pad_abort_clkena", out_clkena, 0);
    chk("pad_abort_frame_done", frame_done, 1);
    for (int i = 0; i < 3; i++) tick(1'b0, 15'h0, 2'b01);
    fd_exp++; fd_since_rst++; y_m = 0; skip_m = 1'b0;
    cmp_px("pad_abort");
    chk_flags("pad_abort");
    do_line(W, 1'b0);
    cmp_px("after_abort");

    // 5: LCD switched off mid-line, then back on.
    tick(1'b0, 15'h0, 2'b10);
    for (int i = 0; i < 80; i++) begin
      d = 15'($urandom);
      tick(1'b1, d, 2'b11);
      model_px(i, d, 1'b0);
    end
    lcd_on = 1'b0;
    tick(1'b0, 15'h0, 2'b11);
    chk("off_out_on", out_on, 0);
    chk("off_clkena", out_clkena, 0);
    y_m = 0; skip_m = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 15'($urandom), 2'b11);
    cmp_px("off_line");
    lcd_on = 1'b1;
    tick(1'b0, 15'h0, 2'b11);
    do_line(W, 1'b0);
    cmp_px("reon_skip");
    do_vblank();
    do_line(W, 1'b0);
    cmp_px("reon_active");
    chk_flags("reon");
`ifdef LCD_FRAMER_STATS_EN
    chk("stats_frame_cnt", frame_cnt, 32'(fd_since_rst));
`endif

    // 6: clock enable held low freezes everything.
    tick(1'b0, 15'h0, 2'b10);
    for (int i = 0; i < 40; i++) begin
      d = 15'($urandom);
      tick(1'b1, d, 2'b11);
      model_px(i, d, 1'b0);
    end
    tick(1'b0, 15'h0, 2'b11);
    chk("pre_freeze_clkena", out_clkena, 0);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 15'($urandom); in_mode = 2'($urandom);
      @(posedge clk); @(negedge clk); #1;
      chk("freeze_clkena", out_clkena, 0);
      chk("freeze_data", out_data, last_px);
      chk("freeze_mode", out_mode, 2'b11);
      chk("freeze_on", out_on, 1);
    end
    ce = 1'b1;
    tick(1'b0, 15'h0, 2'b11);
    for (int i = 40; i < W; i++) begin
      d = 15'($urandom);
      tick(1'b1, d, 2'b11);
      model_px(i, d, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 15'h0, 2'b00);
    model_line_end(W, 1'b0);
    cmp_px("freeze_line");
    chk_flags("freeze");

    // Asynchronous reset mid-line.
    tick(1'b0, 15'h0, 2'b10);
    for (int i = 0; i < 30; i++) begin
      d = 15'($urandom);
      tick(1'b1, d, 2'b11);
      model_px(i, d, 1'b0);
    end
    cmp_px("pre_reset");
    #2 reset_n = 1'b0;
    #1;
    chk("arst_clkena", out_clkena, 0); chk("arst_data", out_data, 0);
    chk("arst_mode", out_mode, 0);     chk("arst_on", out_on, 0);
    chk("arst_err_short", err_short, 0); chk("arst_err_long", err_long, 0);
    @(negedge clk); reset_n = 1'b1; #1;
    y_m = 0; skip_m = 1'b1; short_m = 0; long_m = 0; fd_since_rst = 0;
    is_gbc = 1'b0;
    tick(1'b0, 15'h0, 2'b00);
    do_line(W, 1'b0);
    cmp_px("post_reset_skip");
    chk("post_reset_err_short", err_short, short_m);
    chk("post_reset_err_long", err_long, long_m);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
